output_neuron_mac: RTL

- Output-layer neuron directly downstream of the four hidden neurons.
- Captures four 10-bit hidden activations (unsigned Q3.7), the signed weights and the bias on a start pulse.
- Multiply-accumulates one term per cycle, applies ReLU and rescales back to Q3.7, then holds the result under a valid/ready handshake.
- Time-multiplexes one multiplier to keep area low on the tapeout tile.

---
 rtl/output_neuron_mac.sv | 139 +++++++++++++
 1 files changed

// File: rtl/output_neuron_mac.sv
// Purpose: output-layer neuron; one shared multiplier computes sum(h*w) plus bias, then applies ReLU and rescales to Q3.7.
// Latency: valid_o rises 5 cycles after the edge that samples start_i (4 MAC cycles, then the result register).
// Backpressure: the result stays in DONE until valid_o & ready_i; start_i is ignored while busy_o is high.
// Optional: define OUTPUT_NEURON_SAT_EN to clamp results above 1023 to 1023 instead of wrapping modulo 1024.
module output_neuron_mac #(
    parameter int H_W        = 10,
    parameter int W_W        = 8,
    parameter int ACC_W      = 21,
    parameter int FRAC_SHIFT = 6
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic [H_W-1:0]        h0_i,
    input  logic [H_W-1:0]        h1_i,
    input  logic [H_W-1:0]        h2_i,
    input  logic [H_W-1:0]        h3_i,
    input  logic [W_W-1:0]        w0_i,
    input  logic [W_W-1:0]        w1_i,
    input  logic [W_W-1:0]        w2_i,
    input  logic [W_W-1:0]        w3_i,
    input  logic [W_W-1:0]        bias_i,
    output logic                  busy_o,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic [H_W-1:0]        y_o,
    output logic                  neg_o
);

    // Bias is Q1.6; the accumulator is Q.13, so the bias moves up by 7 bits.
    localparam int BIAS_SHIFT = 7;
    localparam int PROD_W     = H_W + 1 + W_W;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MAC  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                  state;
    logic [H_W-1:0]          h_q [4];
    logic signed [W_W-1:0]   w_q [4];
    logic signed [ACC_W-1:0] acc;
    logic [1:0]              idx;

    logic [H_W-1:0]          h_sel;
    logic signed [W_W-1:0]   w_sel;
    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W-1:0] acc_nxt;
    logic signed [ACC_W-1:0] bias_ext;
    logic [H_W-1:0]          y_res;

    assign h_sel = h_q[idx];
    assign w_sel = w_q[idx];

    // Activation is unsigned, so it is widened with a zero sign bit before the signed multiply.
    assign prod     = $signed({1'b0, h_sel}) * w_sel;
    assign acc_nxt  = acc + ACC_W'(prod);
    assign bias_ext = {{(ACC_W-W_W-BIAS_SHIFT){bias_i[W_W-1]}}, bias_i, {BIAS_SHIFT{1'b0}}};

`ifdef OUTPUT_NEURON_SAT_EN
    logic [ACC_W-FRAC_SHIFT-1:0] r;
    assign r = acc[ACC_W-1:FRAC_SHIFT];

    // ReLU, then clamp anything beyond the Q3.7 range to its maximum.
    always_comb begin
        y_res = '0;
        if (!acc[ACC_W-1]) begin
            if (r > {{(ACC_W-FRAC_SHIFT-H_W){1'b0}}, {H_W{1'b1}}})
                y_res = {H_W{1'b1}};
            else
                y_res = r[H_W-1:0];
        end
    end
`else
    // ReLU, then keep the low Q3.7 bits of the rescaled value (wraps on overflow).
    always_comb begin
        y_res = '0;
        if (!acc[ACC_W-1])
            y_res = acc[FRAC_SHIFT+H_W-1:FRAC_SHIFT];
    end
`endif

    // Control FSM: capture on start, four MAC cycles, then hold the result under valid/ready.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state   <= S_IDLE;
            acc     <= '0;
            idx     <= '0;
            busy_o  <= 1'b0;
            valid_o <= 1'b0;
            y_o     <= '0;
            neg_o   <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                h_q[i] <= '0;
                w_q[i] <= '0;
            end
        end else begin
            case (state)
                S_IDLE: begin
                    if (start_i) begin
                        h_q[0] <= h0_i;
                        h_q[1] <= h1_i;
                        h_q[2] <= h2_i;
                        h_q[3] <= h3_i;
                        w_q[0] <= w0_i;
                        w_q[1] <= w1_i;
                        w_q[2] <= w2_i;
                        w_q[3] <= w3_i;
                        acc    <= bias_ext;
                        idx    <= '0;
                        busy_o <= 1'b1;
                        state  <= S_MAC;
                    end
                end
                S_MAC: begin
                    acc <= acc_nxt;
                    idx <= idx + 2'd1;
                    if (idx == 2'd3)
                        state <= S_DONE;
                end
                S_DONE: begin
                    // First DONE cycle registers the result; afterwards it is held until accepted.
                    if (!valid_o) begin
                        valid_o <= 1'b1;
                        y_o     <= y_res;
                        neg_o   <= acc[ACC_W-1];
                    end else if (ready_i) begin
                        valid_o <= 1'b0;
                        busy_o  <= 1'b0;
                        state   <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
